// File: rtl/feature_if.sv
// Score stream between pipeline stages: valid/ready handshake carrying a small
// vector of signed features, of which the classifier uses element 0.
interface feature_if #(
  parameter int FW           = 8,
  parameter int NUM_FEATURES = 1
);
  typedef logic signed [FW-1:0] feature_type;

  logic        valid;
  logic        ready;
  feature_type features [NUM_FEATURES];

  modport master (output valid, output features, input ready);
  modport slave  (input valid, input features, output ready);
endinterface

// File: rtl/argmax_classifier.sv
// Final pipeline stage: picks the best of NUM_CLASSES streamed scores per frame
// and reports index, score, best-minus-second margin and a low-confidence flag.
module argmax_classifier #(
  parameter int          NUM_CLASSES     = 10,
  parameter int unsigned LOW_CONF_MARGIN = 0,
  parameter int          FW              = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  feature_if.slave                       features_in,
  output logic                           class_valid,
  input  logic                           class_ready,
  output logic [$clog2(NUM_CLASSES)-1:0] class_index,
  output logic signed [FW-1:0]           class_score,
  output logic [FW:0]                    class_margin,
  output logic                           low_conf,
  output logic [15:0]                    frame_count
);
  localparam int                 IW        = $clog2(NUM_CLASSES);
  localparam logic [IW-1:0]      LAST_BEAT = IW'(NUM_CLASSES - 1);
  localparam logic signed [FW-1:0] MOST_NEG = {1'b1, {(FW-1){1'b0}}};

  typedef enum logic {ST_ACCUM, ST_RESULT} state_e;

  state_e                state_q, state_d;
  logic [IW-1:0]         beat_cnt_q, beat_cnt_d;
  logic [IW-1:0]         best_idx_q, best_idx_d;
  logic signed [FW-1:0]  best_q, best_d;
  logic signed [FW-1:0]  second_q, second_d;
  logic [IW-1:0]         class_index_q;
  logic signed [FW-1:0]  class_score_q;
  logic [FW:0]           class_margin_q;
  logic                  low_conf_q;
  logic [15:0]           frame_count_q;

  logic                  beat_acc;
  logic                  last_beat;
  logic                  result_hs;
  logic signed [FW-1:0]  x;
  logic [FW:0]           margin_d;
  logic                  low_conf_d;

  assign x         = features_in.features[0];
  assign beat_acc  = features_in.valid && (state_q == ST_ACCUM);
  assign last_beat = (beat_cnt_q == LAST_BEAT);
  assign result_hs = (state_q == ST_RESULT) && class_ready;

  // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    best_d     = best_q;
    second_d   = second_q;
    best_idx_d = best_idx_q;

    if (beat_acc) begin
      if (beat_cnt_q == '0) begin
        best_d     = x;
        best_idx_d = '0;
        second_d   = MOST_NEG;
      end else if (x > best_q) begin
        second_d   = best_q;
        best_d     = x;
        best_idx_d = beat_cnt_q;
      end else if (x > second_q) begin
        second_d = x;
      end

      if (last_beat) begin
        beat_cnt_d = '0;
        state_d    = ST_RESULT;
      end else begin
        beat_cnt_d = beat_cnt_q + 1'b1;
      end
    end

    if (result_hs) state_d = ST_ACCUM;
  end

  // Sign-extend by one bit so best - second never overflows; best >= second always.
  assign margin_d = {best_d[FW-1], best_d} - {second_d[FW-1], second_d};

  if (LOW_CONF_MARGIN == 0) begin : g_no_low_conf
    assign low_conf_d = 1'b0;
  end else begin : g_low_conf
    assign low_conf_d = (32'(margin_d) < LOW_CONF_MARGIN);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_ACCUM;
      beat_cnt_q     <= '0;
      best_idx_q     <= '0;
      class_index_q  <= '0;
      class_score_q  <= '0;
      class_margin_q <= '0;
      low_conf_q     <= 1'b0;
      frame_count_q  <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      best_idx_q <= best_idx_d;
      if (beat_acc && last_beat) begin
        class_index_q  <= best_idx_d;
        class_score_q  <= best_d;
        class_margin_q <= margin_d;
        low_conf_q     <= low_conf_d;
      end
      if (result_hs) frame_count_q <= frame_count_q + 16'd1;
    end
  end

  // NOTE: running best/second are reloaded by beat 0 of every frame, so they need no reset.
  always_ff @(posedge clock) begin
    best_q   <= best_d;
    second_q <= second_d;
  end

  assign features_in.ready = (state_q == ST_ACCUM);
  assign class_valid       = (state_q == ST_RESULT);
  assign class_index       = class_index_q;
  assign class_score       = class_score_q;
  assign class_margin      = class_margin_q;
  assign low_conf          = low_conf_q;
  assign frame_count       = frame_count_q;
endmodule
